c4_board_driver: RTL

Board-state and display end of the Connect Four column-select path. It accepts a binary column index (0-6) with a valid/ready handshake and drops the current player's token into the lowest empty row of that column. It tracks whose turn it is and decodes the board back into a time-multiplexed one-hot column scan with per-player row lines for the LED matrix.

---
 rtl/c4_pkg.sv | 41 ++++
 rtl/c4_scan_mux.sv | 70 +++++++
 rtl/c4_board_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// Shared definitions for the Connect Four board driver: board geometry,
// cell encoding, FSM states and field widths.
// No ports; imported by c4_board_driver and c4_scan_mux.
package c4_pkg;

  localparam int COLS       = 7;
  localparam int ROWS       = 6;
  localparam int MAX_TOKENS = 42;

  localparam int COL_W  = 3;
  localparam int ROW_W  = 3;
  localparam int CNT_W  = 6;
  localparam int CELL_W = 2;

  // Board vector layout: cell(col, row) occupies bits [cell_lsb(col,row) +: CELL_W],
  // columns are stored consecutively, row 0 (bottom) first inside each column.
  localparam int BOARD_W = COLS * ROWS * CELL_W;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P0    = 2'b01;
  localparam cell_t CELL_P1    = 2'b10;

  localparam logic [COL_W-1:0] LAST_COL   = 3'd6;
  localparam logic [ROW_W-1:0] LAST_ROW   = 3'd5;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_TOKENS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WRITE  = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Bit offset of the low bit of cell(col, row) inside the board vector.
  function automatic int cell_lsb(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    return (int'(col) * ROWS + int'(row)) * CELL_W;
  endfunction

endpackage

// File: rtl/c4_scan_mux.sv
// LED matrix scanner: holds each column for SCAN_DIV cycles, cycles the
// column 0..6, and extracts per-player row lines for the scanned column.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   board             packed board state (see c4_pkg layout)
//   led_col           one-hot active-high column select (registered)
//   led_p0, led_p1    row lines of the scanned column, bit0 = bottom row
module c4_scan_mux
  import c4_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BOARD_W-1:0] board,
  output logic [COLS-1:0]    led_col,
  output logic [ROWS-1:0]    led_p0,
  output logic [ROWS-1:0]    led_p1
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COLS-1:0]  led_col_q, led_col_d;

  // Divider and column advance; led_col is decoded from the next column so it stays registered.
  always_comb begin
    div_d = div_q;
    col_d = col_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (col_q == LAST_COL) begin
        col_d = '0;
      end else begin
        col_d = col_q + 3'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    led_col_d = 7'b0000001 << col_d;
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      col_q     <= '0;
      led_col_q <= 7'b0000001;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      led_col_q <= led_col_d;
    end
  end

  // Row lines follow the registered column and the live board with no extra delay.
  always_comb begin
    led_p0 = '0;
    led_p1 = '0;
    for (int r = 0; r < ROWS; r++) begin
      led_p0[r] = (board[cell_lsb(col_q, ROW_W'(r)) +: CELL_W] == CELL_P0);
      led_p1[r] = (board[cell_lsb(col_q, ROW_W'(r)) +: CELL_W] == CELL_P1);
    end
  end

  assign led_col = led_col_q;

endmodule

// File: rtl/c4_board_driver.sv
// Connect Four board state machine: accepts a column index, drops the current
// player's token into the lowest empty row, tracks turn and token count, and
// drives the LED matrix through c4_scan_mux.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   drop_valid, drop_col     drop request and binary column (7 is invalid)
//   drop_ready               high only while idle
//   board_clr                clears the board while idle
//   drop_ack, drop_err       one-cycle result pulses
//   player                   whose turn it is
//   move_count, board_full   token count (0-42) and full flag
//   led_col, led_p0, led_p1  LED matrix scan outputs
module c4_board_driver
  import c4_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drop_valid,
  input  logic [COL_W-1:0] drop_col,
  output logic             drop_ready,
  input  logic             board_clr,
  output logic             drop_ack,
  output logic             drop_err,
  output logic             player,
  output logic [CNT_W-1:0] move_count,
  output logic             board_full,
  output logic [COLS-1:0]  led_col,
  output logic [ROWS-1:0]  led_p0,
  output logic [ROWS-1:0]  led_p1
);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic               player_q, player_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               full_q, full_d;
  cell_t              search_cell;

  // Next-state and datapath logic. Status outputs are derived from the next
  // state so that they are registered yet line up with the state they report.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    board_d     = board_q;
    player_d    = player_q;
    count_d     = count_q;
    search_cell = board_q[cell_lsb(col_q, row_q) +: CELL_W];

    case (state_q)
      ST_IDLE: begin
        if (board_clr) begin
          board_d  = '0;
          player_d = 1'b0;
          count_d  = '0;
        end else if (drop_valid) begin
          if (drop_col <= LAST_COL) begin
            col_d   = drop_col;
            row_d   = '0;
            state_d = ST_SEARCH;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (search_cell == CELL_EMPTY) begin
          state_d = ST_WRITE;
        end else if (row_q == LAST_ROW) begin
          // Column (or the whole board) is full: rejected without writing.
          state_d = ST_ERR;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      ST_WRITE: begin
        board_d[cell_lsb(col_q, row_q) +: CELL_W] = player_q ? CELL_P1 : CELL_P0;
        player_d = ~player_q;
        count_d  = count_q + 6'd1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d   = (state_d == ST_WRITE);
    err_d   = (state_d == ST_ERR);
    ready_d = (state_d == ST_IDLE);
    full_d  = (count_d == FULL_COUNT);
  end

  // State, board and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      board_q  <= '0;
      player_q <= 1'b0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      board_q  <= board_d;
      player_q <= player_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
    end
  end

  assign drop_ready = ready_q;
  assign drop_ack   = ack_q;
  assign drop_err   = err_q;
  assign player     = player_q;
  assign move_count = count_q;
  assign board_full = full_q;

  c4_scan_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .board   (board_q),
    .led_col (led_col),
    .led_p0  (led_p0),
    .led_p1  (led_p1)
  );

endmodule
